// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter / fetch sequencer on the consumer side of the
// branch lookup table. Drives the table index straight from the instruction
// field and samples the returned target in the same cycle. It steps the PC
// through IDLE/RUN/HALT and keeps a single-entry link register for call/return.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | after reset; pc held at START_ADDR until start
//   RUN    | fetching; pc advances by halt/stall/ret/branch/increment
//   HALT   | halt seen; pc frozen at halt address, done high until start
module pc_fetch_ctrl #(
    parameter int PC_W       = 10,
    parameter int IDX_W      = 4,
    parameter int TGT_W      = 8,
    parameter int REL_BRANCH = 0,
    parameter int START_ADDR = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    input  logic             br_en,
    input  logic             br_cond,
    input  logic             br_link,
    input  logic             ret_en,
    input  logic [IDX_W-1:0] instr_idx,
    input  logic [TGT_W-1:0] branch_target,
    output logic [IDX_W-1:0] lut_index,
    output logic [PC_W-1:0]  pc,
    output logic             done,
    output logic             running
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_t          state_q, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic [PC_W-1:0] link_q, link_nxt;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] tgt_zext;
    logic [PC_W-1:0] tgt_sext;
    logic [PC_W-1:0] br_pc;

    // The table answers combinationally, so the index is a straight pass-through.
    assign lut_index = instr_idx;
    assign pc        = pc_q;

    // All PC arithmetic wraps modulo 2**PC_W by truncation to PC_W bits.
    assign pc_inc   = pc_q + PC_W'(1);
    assign tgt_zext = {{(PC_W-TGT_W){1'b0}}, branch_target};
    assign tgt_sext = {{(PC_W-TGT_W){branch_target[TGT_W-1]}}, branch_target};
    assign br_pc    = (REL_BRANCH != 0) ? (pc_q + tgt_sext) : tgt_zext;

    // Next-state and next-PC selection; in RUN: halt > stall > ret > taken branch > increment.
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        link_nxt  = link_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nxt = S_RUN;
                    pc_nxt    = START_PC;
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_nxt = S_HALT;
                end else if (stall) begin
                    pc_nxt = pc_q;
                end else if (ret_en) begin
                    pc_nxt = link_q;
                end else if (br_en && br_cond) begin
                    pc_nxt = br_pc;
                    if (br_link) begin
                        link_nxt = pc_inc;
                    end
                end else begin
                    pc_nxt = pc_inc;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pc_nxt    = START_PC;
            end
        endcase
    end

    // State, PC, link and status flags; done/running decode the next state so they track state exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            link_q  <= '0;
            done    <= 1'b0;
            running <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            link_q  <= link_nxt;
            done    <= (state_nxt == S_HALT);
            running <= (state_nxt == S_RUN);
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: one absolute-target and one relative-target
// instance share the stimulus; expected values are hand-computed constants.
module tb_pc_fetch_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, halt, stall, br_en, br_cond, br_link, ret_en;
    logic [3:0] instr_idx;
    logic [7:0] branch_target;

    logic [3:0] a_lut, r_lut;
    logic [9:0] a_pc, r_pc;
    logic       a_done, a_running, r_done, r_running;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.REL_BRANCH(0)) u_abs (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
        .br_en(br_en), .br_cond(br_cond), .br_link(br_link), .ret_en(ret_en),
        .instr_idx(instr_idx), .branch_target(branch_target),
        .lut_index(a_lut), .pc(a_pc), .done(a_done), .running(a_running)
    );

    pc_fetch_ctrl #(.REL_BRANCH(1)) u_rel (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
        .br_en(br_en), .br_cond(br_cond), .br_link(br_link), .ret_en(ret_en),
        .instr_idx(instr_idx), .branch_target(branch_target),
        .lut_index(r_lut), .pc(r_pc), .done(r_done), .running(r_running)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_br();
        br_en = 0; br_cond = 0; br_link = 0; ret_en = 0; stall = 0; halt = 0;
    endtask

    task automatic take(input logic [7:0] tgt, input logic link);
        br_en = 1; br_cond = 1; br_link = link; branch_target = tgt;
    endtask

    initial begin
        reset = 1; start = 0; instr_idx = 0; branch_target = 0;
        clr_br();
        step(); step();
        chk("rst_pc", a_pc, 0);
        chk("rst_done", a_done, 0);
        chk("rst_running", a_running, 0);

        // 1: start and count up
        reset = 0;
        step();
        chk("idle_hold_run", a_running, 0);
        start = 1;
        step();
        start = 0;
        chk("start_running", a_running, 1);
        chk("start_pc", a_pc, 0);
        step(); chk("pc_1", a_pc, 1);
        step(); chk("pc_2", a_pc, 2);
        step(); chk("pc_3", a_pc, 3);
        step(); step();
        chk("pc_5", a_pc, 5);

        // 2: absolute taken branch
        take(8'h40, 0); instr_idx = 4'd3;
        #1;
        chk("lut_index", a_lut, 3);
        step();
        chk("abs_branch", a_pc, 10'h040);

        // 4: call / return, with ignored br_link and ignored br_cond
        take(8'h20, 0);
        step(); chk("abs_to_20", a_pc, 10'h020);
        take(8'h80, 1);
        step(); chk("call_80", a_pc, 10'h080);
        br_en = 1; br_cond = 0; br_link = 1; branch_target = 8'h10;
        step(); chk("not_taken_link", a_pc, 10'h081);
        clr_br(); ret_en = 1;
        step(); chk("ret_21", a_pc, 10'h021);
        clr_br(); br_cond = 1; branch_target = 8'h99;
        step(); chk("cond_no_en", a_pc, 10'h022);

        // 6a: stall beats taken branch and return
        clr_br(); stall = 1; take(8'h55, 1);
        step(); chk("stall_branch", a_pc, 10'h022);
        clr_br(); stall = 1; ret_en = 1;
        step(); chk("stall_ret", a_pc, 10'h022);
        clr_br();
        step(); chk("after_stall", a_pc, 10'h023);

        // 5: halt beats taken branch
        halt = 1; take(8'h77, 0);
        step();
        clr_br();
        chk("halt_pc", a_pc, 10'h023);
        chk("halt_done", a_done, 1);
        chk("halt_running", a_running, 0);
        step();
        chk("halt_hold_pc", a_pc, 10'h023);
        chk("halt_hold_done", a_done, 1);
        start = 1;
        step();
        start = 0;
        chk("restart_pc", a_pc, 0);
        chk("restart_done", a_done, 0);
        chk("restart_running", a_running, 1);
        step(); chk("restart_pc1", a_pc, 1);
        start = 1;
        step(); chk("start_in_run", a_pc, 2);
        start = 0;

        // 6b: reset mid-RUN clears link and ignores the branch
        take(8'h30, 1);
        step(); chk("call_30", a_pc, 10'h030);
        reset = 1; take(8'h99, 1);
        step();
        clr_br();
        chk("midrst_pc", a_pc, 0);
        chk("midrst_running", a_running, 0);
        chk("midrst_done", a_done, 0);
        reset = 0; start = 1;
        step();
        start = 0; ret_en = 1;
        step();
        clr_br();
        chk("link_cleared", a_pc, 0);

        // 3: relative target instance
        reset = 1;
        step();
        reset = 0; start = 1;
        step();
        start = 0;
        chk("rel_start", r_pc, 0);
        for (int i = 0; i < 16; i++) step();
        chk("rel_pc_10", r_pc, 10'h010);
        take(8'hFC, 0);
        step(); chk("rel_minus4", r_pc, 10'h00C);
        take(8'hF4, 0);
        step(); chk("rel_to_0", r_pc, 10'h000);
        take(8'hFF, 0);
        step(); chk("rel_wrap_neg", r_pc, 10'h3FF);
        clr_br();
        step(); chk("inc_wrap", r_pc, 10'h000);
        take(8'h7F, 0);
        step(); chk("rel_plus127", r_pc, 10'h07F);
        chk("abs_same_tgt", a_pc, 10'h07F);
        take(8'h81, 0);
        step(); chk("rel_minus127", r_pc, 10'h000);
        chk("abs_zext", a_pc, 10'h081);
        clr_br();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
